seq_pattern_tx: RTL and testbench

//   Serial pattern transmitter: drives one bit per clock on x, MSB first.
//   The frame is a PAT_W-bit pattern, repeated 1..2^REP_W-1 times, with an optional

---
 rtl/seq_pattern_tx_if.sv | 31 +++
 rtl/seq_pattern_tx.sv | 132 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: control and serial-output bundle of the pattern transmitter.
//   master modport: the controller side (drives the frame request, watches the serial stream)
//   slave modport : the transmitter side (seq_pattern_tx)
//   start, use_default, pattern_in, rep_cnt, gap_len : frame request fields
//   x, x_valid, frame_start, busy, done              : serial stream and status
interface seq_pattern_tx_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned REP_W = 4,
    parameter int unsigned GAP_W = 3
);
    logic             start;
    logic             use_default;
    logic [PAT_W-1:0] pattern_in;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             x;
    logic             x_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output start, use_default, pattern_in, rep_cnt, gap_len,
        input  x, x_valid, frame_start, busy, done
    );

    modport slave (
        input  start, use_default, pattern_in, rep_cnt, gap_len,
        output x, x_valid, frame_start, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, one bit per clock, MSB first.
// A frame is a PAT_W-bit pattern repeated 1..2^REP_W-1 times with an optional
// gap of idle (zero, x_valid=0) cycles between repetitions.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : seq_pattern_tx_if.slave
//           start/use_default/pattern_in/rep_cnt/gap_len are sampled only in idle;
//           x/x_valid/frame_start/busy/done are all registered.
module seq_pattern_tx #(
    parameter int unsigned     PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter int unsigned     REP_W   = 4,
    parameter int unsigned     GAP_W   = 3
) (
    input  logic          clk,
    input  logic          reset,
    seq_pattern_tx_if.slave bus
);
    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

    state_e           state;
    logic [PAT_W-1:0] pat;
    logic [REP_W-1:0] reps_left;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] bit_idx;   // index of the bit currently on x
    logic             x;
    logic             x_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    logic [PAT_W-1:0] pat_sel;
    logic [REP_W-1:0] reps_sel;

    assign pat_sel  = bus.use_default ? PATTERN : bus.pattern_in;
    assign reps_sel = (bus.rep_cnt == '0) ? REP_W'(1) : bus.rep_cnt;

    assign bus.x           = x;
    assign bus.x_valid     = x_valid;
    assign bus.frame_start = frame_start;
    assign bus.busy        = busy;
    assign bus.done        = done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            pat         <= '0;
            reps_left   <= '0;
            gap         <= '0;
            gap_cnt     <= '0;
            bit_idx     <= '0;
            x           <= 1'b0;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        // First bit goes out on the same edge that accepts the request.
                        pat         <= pat_sel;
                        reps_left   <= reps_sel;
                        gap         <= bus.gap_len;
                        bit_idx     <= MSB_IDX;
                        x           <= pat_sel[PAT_W-1];
                        x_valid     <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        state       <= StShift;
                    end else begin
                        x           <= 1'b0;
                        x_valid     <= 1'b0;
                        frame_start <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                StShift: begin
                    if (bit_idx != '0) begin
                        bit_idx     <= bit_idx - IDX_W'(1);
                        x           <= pat[bit_idx - IDX_W'(1)];
                        frame_start <= 1'b0;
                    end else if (reps_left > REP_W'(1)) begin
                        reps_left <= reps_left - REP_W'(1);
                        if (gap != '0) begin
                            gap_cnt     <= gap;
                            x           <= 1'b0;
                            x_valid     <= 1'b0;
                            frame_start <= 1'b0;
                            state       <= StGap;
                        end else begin
                            bit_idx     <= MSB_IDX;
                            x           <= pat[PAT_W-1];
                            frame_start <= 1'b1;
                        end
                    end else begin
                        x           <= 1'b0;
                        x_valid     <= 1'b0;
                        frame_start <= 1'b0;
                        done        <= 1'b1;
                        state       <= StDone;
                    end
                end
                StGap: begin
                    // gap_cnt holds the number of gap cycles still to show, including this one.
                    if (gap_cnt == GAP_W'(1)) begin
                        bit_idx     <= MSB_IDX;
                        x           <= pat[PAT_W-1];
                        x_valid     <= 1'b1;
                        frame_start <= 1'b1;
                        state       <= StShift;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: randomized self-checking bench for seq_pattern_tx.
// Expected per-cycle outputs are generated from the frame rules (bits, gaps, done, idle).
module tb_seq_pattern_tx;
    localparam int PAT_W = 4;
    localparam int REP_W = 4;
    localparam int GAP_W = 3;
    localparam logic [3:0] DEF_PAT = 4'b1001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_pattern_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) bus ();

    seq_pattern_tx #(
        .PAT_W  (PAT_W),
        .PATTERN(DEF_PAT),
        .REP_W  (REP_W),
        .GAP_W  (GAP_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observation vector order: {x, x_valid, frame_start, busy, done}
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];

    function automatic logic [4:0] now_obs();
        return {bus.x, bus.x_valid, bus.frame_start, bus.busy, bus.done};
    endfunction

    // Reference: the cycle-by-cycle output sequence starting at the cycle after the start edge.
    task automatic build_expected(input logic use_def, input logic [3:0] pin,
                                  input int rep, input int gap);
        logic [3:0] p;
        int reps;
        p    = use_def ? DEF_PAT : pin;
        reps = (rep == 0) ? 1 : rep;
        exp_q.delete();
        for (int r = 0; r < reps; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp_q.push_back({p[b], 1'b1, (b == PAT_W - 1), 1'b1, 1'b0});
            if (r < reps - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00011);
        exp_q.push_back(5'b00000);
    endtask

    task automatic launch(input logic use_def, input logic [3:0] pin,
                          input int rep, input int gap);
        @(negedge clk);
        bus.use_default = use_def;
        bus.pattern_in  = pin;
        bus.rep_cnt     = REP_W'(rep);
        bus.gap_len     = GAP_W'(gap);
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
        // Scramble the request fields: they must not be re-sampled mid-frame.
        bus.use_default = 1'($urandom);
        bus.pattern_in  = 4'($urandom);
        bus.rep_cnt     = 4'($urandom);
        bus.gap_len     = 3'($urandom);
    endtask

    // Record n cycles; start/reset are raised for the edge following sample start_at/reset_at.
    task automatic capture(input int n, input int start_at, input int reset_at);
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            obs_q.push_back(now_obs());
            bus.start = (i == start_at);
            reset     = (i == reset_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (now_obs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 00000", now_obs());
        end
        reset = 1'b0;
    endtask

    task automatic test_default_single();
        launch(1'b1, 4'($urandom), 1, 0);
        build_expected(1'b1, 4'b0000, 1, 0);
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL default_single cycle %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] win;
        int hits;
        launch(1'b1, 4'($urandom), 2, 0);
        build_expected(1'b1, 4'b0000, 2, 0);
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        win  = 4'b0000;
        hits = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            win = {win[2:0], obs_q[i][4]};
            if (win == 4'b1001 && obs_q[i][3] === 1'b1) hits++;
        end
        n_tests++;
        if (hits != 2) begin
            n_fail++;
            $display("FAIL back_to_back_1001_hits: got %0d want 2", hits);
        end
    endtask

    task automatic test_gap_frame();
        int fs;
        launch(1'b0, 4'b1100, 3, 2);
        build_expected(1'b0, 4'b1100, 3, 2);
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gap_frame cycle %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        fs = 0;
        foreach (obs_q[i]) if (obs_q[i][2] === 1'b1) fs++;
        n_tests++;
        if (fs != 3) begin
            n_fail++;
            $display("FAIL gap_frame_starts: got %0d want 3", fs);
        end
        n_tests++;
        if (obs_q[16][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_frame_done_cycle17: got %b want 1", obs_q[16][0]);
        end
    endtask

    task automatic test_rep_zero_and_ignored_start();
        logic [3:0] p;
        int g;
        int done_idx;
        p = 4'($urandom);
        g = $urandom_range(0, 7);
        // rep_cnt=0 with an extra start pulse while shifting.
        launch(1'b0, p, 0, g);
        build_expected(1'b0, p, 0, g);
        capture(exp_q.size(), 2, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rep_zero cycle %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        // Start pulse sampled in DONE must be ignored.
        launch(1'b1, p, 1, g);
        build_expected(1'b1, p, 1, g);
        done_idx = exp_q.size() - 2;
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b00000);
        capture(exp_q.size(), done_idx, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL start_in_done cycle %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [3:0] p;
        launch(1'b1, 4'($urandom), 2, 0);
        build_expected(1'b1, 4'b0000, 2, 0);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        repeat (3) exp_q.push_back(5'b00000);
        capture(6, -1, 2);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL mid_reset cycle %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
        p = 4'($urandom);
        launch(1'b0, p, 2, 1);
        build_expected(1'b0, p, 2, 1);
        capture(exp_q.size(), -1, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL after_reset cycle %0d: got %b want %b", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_start_same_edge();
        @(negedge clk);
        bus.use_default = 1'b1;
        bus.rep_cnt     = 4'd1;
        reset           = 1'b1;
        bus.start       = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        capture(4, -1, -1);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs_q[i] !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_start_same_edge cycle %0d: got %b want 00000", i + 1, obs_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic ud;
        logic [3:0] p;
        int r;
        int g;
        for (int t = 0; t < 12; t++) begin
            ud = 1'($urandom);
            p  = 4'($urandom);
            r  = $urandom_range(0, 15);
            g  = $urandom_range(0, 7);
            launch(ud, p, r, g);
            build_expected(ud, p, r, g);
            capture(exp_q.size(), -1, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random[%0d] ud=%0d pat=%b rep=%0d gap=%0d cycle %0d: got %b want %b",
                             t, ud, p, r, g, i + 1, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.use_default = 1'b0;
        bus.pattern_in  = '0;
        bus.rep_cnt     = '0;
        bus.gap_len     = '0;
        test_reset();
        test_default_single();
        test_back_to_back();
        test_gap_frame();
        test_rep_zero_and_ignored_start();
        test_mid_frame_reset();
        test_reset_start_same_edge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
